// File: rtl/tta_pkg.sv
// Shared types for the transport unit: operand kinds, op-word field layout and FSM states.
`default_nettype none

package tta_pkg;

  typedef enum logic [3:0] {
    KIND_REG     = 4'd0,
    KIND_IMM     = 4'd1,
    KIND_MEM_ABS = 4'd2,
    KIND_MEM_IND = 4'd3
  } kind_e;

  localparam int c_FIELD_W      = 4;
  localparam int c_SRC_KIND_LSB = 28;
  localparam int c_SRC_REG_LSB  = 24;
  localparam int c_DST_KIND_LSB = 20;
  localparam int c_DST_REG_LSB  = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SRC      = 3'd1,
    S_SRC_WAIT = 3'd2,
    S_DST      = 3'd3,
    S_DST_WAIT = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_e;

  function automatic logic [3:0] op_src_kind(input logic [31:0] op);
    return op[c_SRC_KIND_LSB +: c_FIELD_W];
  endfunction

  function automatic logic [3:0] op_src_reg(input logic [31:0] op);
    return op[c_SRC_REG_LSB +: c_FIELD_W];
  endfunction

  function automatic logic [3:0] op_dst_kind(input logic [31:0] op);
    return op[c_DST_KIND_LSB +: c_FIELD_W];
  endfunction

  function automatic logic [3:0] op_dst_reg(input logic [31:0] op);
    return op[c_DST_REG_LSB +: c_FIELD_W];
  endfunction

  // Any of the four kinds may be a source; an immediate cannot be a destination.
  function automatic logic op_is_legal(input logic [31:0] op);
    logic [3:0] sk;
    logic [3:0] dk;
    sk = op_src_kind(op);
    dk = op_dst_kind(op);
    return (sk <= KIND_MEM_IND) &&
           ((dk == KIND_REG) || (dk == KIND_MEM_ABS) || (dk == KIND_MEM_IND));
  endfunction

endpackage

`default_nettype wire

// File: rtl/transport_unit_if.sv
// Data-bus bundle between the transport unit (master) and memory (slave).
`default_nettype none

interface transport_unit_if;
  logic        dbus_valid_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ready_i;
  logic [31:0] dbus_rdata_i;

  modport master (
    output dbus_valid_o, dbus_we_o, dbus_addr_o, dbus_wdata_o,
    input  dbus_ready_i, dbus_rdata_i
  );

  modport slave (
    input  dbus_valid_o, dbus_we_o, dbus_addr_o, dbus_wdata_o,
    output dbus_ready_i, dbus_rdata_i
  );
endinterface

`default_nettype wire

// File: rtl/transport_unit_reg_file.sv
// 16x32 register file: two asynchronous read ports, one synchronous write port.
`default_nettype none

module reg_file (
  input  wire logic        clk_i,
  input  wire logic        rst_ni,
  input  wire logic [3:0]  i_raddr_a,
  input  wire logic [3:0]  i_raddr_b,
  output logic      [31:0] o_rdata_a,
  output logic      [31:0] o_rdata_b,
  input  wire logic        i_we,
  input  wire logic [3:0]  i_waddr,
  input  wire logic [31:0] i_wdata
);

  logic [31:0] r_regs [16];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/transport_unit.sv
// Transport-triggered move unit: copies one value from a src (reg/imm/mem) to a dst (reg/mem).
`default_nettype none

module transport_unit
  import tta_pkg::*;
(
  input  wire logic        clk_i,
  input  wire logic        rst_ni,
  input  wire logic [31:0] op_i,
  input  wire logic [31:0] src_operand_i,
  input  wire logic [31:0] dst_operand_i,
  input  wire logic        start_i,
  output logic             need_src_operand_o,
  output logic             need_dst_operand_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  transport_unit_if.master dbus
);

  state_e      r_state;
  logic [31:0] r_op;
  logic [31:0] r_src_opnd;
  logic [31:0] r_dst_opnd;
  logic [31:0] r_data;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_done;
  logic        r_err;

  logic [3:0]  w_in_src_kind;
  logic [3:0]  w_in_dst_kind;
  logic [3:0]  w_src_kind;
  logic [3:0]  w_dst_kind;
  logic [31:0] w_src_rdata;
  logic [31:0] w_dst_rdata;
  logic        w_rf_we;
  logic        w_unused_op_low;

  assign w_in_src_kind = op_src_kind(op_i);
  assign w_in_dst_kind = op_dst_kind(op_i);
  assign w_src_kind    = op_src_kind(r_op);
  assign w_dst_kind    = op_dst_kind(r_op);
  assign w_unused_op_low = ^r_op[15:0];

  assign need_src_operand_o = (w_in_src_kind == KIND_IMM) || (w_in_src_kind == KIND_MEM_ABS);
  assign need_dst_operand_o = (w_in_dst_kind == KIND_MEM_ABS);

  assign w_rf_we = (r_state == S_DST) && (w_dst_kind == KIND_REG);

  reg_file u_reg_file (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_raddr_a (op_src_reg(r_op)),
    .i_raddr_b (op_dst_reg(r_op)),
    .o_rdata_a (w_src_rdata),
    .o_rdata_b (w_dst_rdata),
    .i_we      (w_rf_we),
    .i_waddr   (op_dst_reg(r_op)),
    .i_wdata   (r_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_src_opnd <= '0;
      r_dst_opnd <= '0;
      r_data     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_op       <= op_i;
            r_src_opnd <= src_operand_i;
            r_dst_opnd <= dst_operand_i;
            if (op_is_legal(op_i)) begin
              r_state <= S_SRC;
            end else begin
              r_state <= S_ERR;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        S_SRC: begin
          if (w_src_kind == KIND_REG) begin
            r_data  <= w_src_rdata;
            r_state <= S_DST;
          end else if (w_src_kind == KIND_IMM) begin
            r_data  <= r_src_opnd;
            r_state <= S_DST;
          end else begin
            r_addr  <= (w_src_kind == KIND_MEM_ABS) ? r_src_opnd : w_src_rdata;
            r_we    <= 1'b0;
            r_state <= S_SRC_WAIT;
          end
        end
        S_SRC_WAIT: begin
          if (dbus.dbus_ready_i) begin
            r_data  <= dbus.dbus_rdata_i;
            r_state <= S_DST;
          end
        end
        S_DST: begin
          // Register destinations are written by the reg_file port during this cycle.
          if (w_dst_kind == KIND_REG) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_addr  <= (w_dst_kind == KIND_MEM_ABS) ? r_dst_opnd : w_dst_rdata;
            r_wdata <= r_data;
            r_we    <= 1'b1;
            r_state <= S_DST_WAIT;
          end
        end
        S_DST_WAIT: begin
          if (dbus.dbus_ready_i) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid is a pure state decode so an asynchronous reset drops it immediately.
  assign dbus.dbus_valid_o = (r_state == S_SRC_WAIT) || (r_state == S_DST_WAIT);
  assign dbus.dbus_we_o    = r_we;
  assign dbus.dbus_addr_o  = r_addr;
  assign dbus.dbus_wdata_o = r_wdata;

  assign busy_o  = (r_state != S_IDLE);
  assign done_o  = r_done;
  assign error_o = r_err;

endmodule

`default_nettype wire

// File: tb/tb_transport_unit.sv
// Randomised bench for transport_unit checked against a transaction-level timeline model.
`default_nettype none

module tb_transport_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] op_i = '0;
  logic [31:0] src_operand_i = '0;
  logic [31:0] dst_operand_i = '0;
  logic        start_i = 1'b0;
  logic        need_src_operand_o, need_dst_operand_o, busy_o, done_o, error_o;

  transport_unit_if dbus_if ();

  transport_unit dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .op_i               (op_i),
    .src_operand_i      (src_operand_i),
    .dst_operand_i      (dst_operand_i),
    .start_i            (start_i),
    .need_src_operand_o (need_src_operand_o),
    .need_dst_operand_o (need_dst_operand_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .error_o            (error_o),
    .dbus               (dbus_if.master)
  );

  always #5 clk_i = ~clk_i;

  // Expected outputs per absolute cycle number; absent cycles mean idle/all-zero.
  typedef struct packed {
    bit          vld;
    bit          we;
    bit          chkw;
    bit          rdy;
    bit          done;
    bit          err;
    bit          busy;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } slot_t;

  slot_t       tl [int];
  logic [31:0] regs [16];
  logic [31:0] mem [logic [31:0]];
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          n_cmp = 0, n_fail = 0;
  int          g_ws = 0, g_wd = 0, g_acc = 0;
  bit          pend_v = 1'b0, pend_existed = 1'b0;
  logic [31:0] pend_a = '0, pend_old = '0;
  logic [31:0] obs_addr = '0, obs_wdata = '0;
  logic        obs_we = 1'b0;
  int          vcnt = 0, done_cnt = 0, last_done = -1, last_err = -1;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic slot_t at(input int c);
    if (tl.exists(c)) return tl[c];
    return '0;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic window(input int c0, input int w, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd);
    slot_t e;
    for (int c = c0; c <= c0 + w; c++) begin
      e = at(c);
      e.vld = 1'b1; e.we = we; e.chkw = we; e.addr = a; e.wdata = wd;
      if (c == c0 + w) begin e.rdy = 1'b1; e.rdata = rd; end
      tl[c] = e;
    end
  endtask

  // Move semantics: done = accept + 3 + sum(1 + wait) over memory accesses.
  task automatic accept(input logic [31:0] op, input logic [31:0] s, input logic [31:0] d);
    logic [3:0]  sk, sr, dk, dr;
    logic [31:0] v, a;
    int          n, t, dn;
    slot_t       e;
    sk = op[31:28]; sr = op[27:24]; dk = op[23:20]; dr = op[19:16];
    n = cyc; g_acc = n; pend_v = 1'b0; v = '0;
    if (sk > 4'd3 || !(dk == 4'd0 || dk == 4'd2 || dk == 4'd3)) begin
      e = at(n + 1); e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1; tl[n + 1] = e;
      return;
    end
    t = n + 2;
    if (sk == 4'd0) v = regs[sr];
    else if (sk == 4'd1) v = s;
    else begin
      a = (sk == 4'd2) ? s : regs[sr];
      v = mem_rd(a);
      window(t, g_ws, 1'b0, a, '0, v);
      t += g_ws + 1;
    end
    if (dk == 4'd0) begin
      regs[dr] = v;
      dn = t + 1;
    end else begin
      a = (dk == 4'd2) ? d : regs[dr];
      pend_v = 1'b1; pend_a = a; pend_existed = mem.exists(a);
      if (pend_existed) pend_old = mem[a];
      mem[a] = v;
      window(t + 1, g_wd, 1'b1, a, v, '0);
      dn = t + g_wd + 2;
    end
    for (int c = n + 1; c <= dn; c++) begin
      e = at(c); e.busy = 1'b1; if (c == dn) e.done = 1'b1; tl[c] = e;
    end
  endtask

  task automatic step(input bit st, input logic [31:0] op, input logic [31:0] s, input logic [31:0] d);
    slot_t e;
    @(posedge clk_i);
    #1;
    e = at(cyc);
    start_i = st; op_i = op; src_operand_i = s; dst_operand_i = d;
    dbus_if.dbus_ready_i = e.vld ? e.rdy : 1'($urandom_range(0, 1));
    dbus_if.dbus_rdata_i = e.rdy ? e.rdata : $urandom;
    if (st && !e.busy) accept(op, s, d);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (!at(cyc + 1).busy) break;
      step(1'b0, $urandom, $urandom, $urandom);
    end
    @(negedge clk_i);
    #1;
  endtask

  task automatic run(input logic [31:0] op, input logic [31:0] s, input logic [31:0] d,
                     input int ws, input int wd);
    g_ws = ws; g_wd = wd;
    step(1'b1, op, s, d);
    wait_idle();
  endtask

  function automatic logic [31:0] mk(input int sk, input int sr, input int dk, input int dr);
    return {4'(sk), 4'(sr), 4'(dk), 4'(dr), 16'h0};
  endfunction

  slot_t e_c;
  always @(negedge clk_i) begin
    if (chk_en) begin
      e_c = at(cyc);
      chk("valid", 32'(dbus_if.dbus_valid_o), 32'(e_c.vld));
      chk("busy", 32'(busy_o), 32'(e_c.busy));
      chk("done", 32'(done_o), 32'(e_c.done));
      chk("error", 32'(error_o), 32'(e_c.err));
      chk("need_src", 32'(need_src_operand_o), 32'((op_i[31:28] == 4'd1) || (op_i[31:28] == 4'd2)));
      chk("need_dst", 32'(need_dst_operand_o), 32'(op_i[23:20] == 4'd2));
      if (e_c.vld) begin
        chk("addr", dbus_if.dbus_addr_o, e_c.addr);
        chk("we", 32'(dbus_if.dbus_we_o), 32'(e_c.we));
        if (e_c.chkw) chk("wdata", dbus_if.dbus_wdata_o, e_c.wdata);
      end
      if (dbus_if.dbus_valid_o) vcnt++;
      if (dbus_if.dbus_valid_o && dbus_if.dbus_ready_i) begin
        obs_addr = dbus_if.dbus_addr_o; obs_we = dbus_if.dbus_we_o; obs_wdata = dbus_if.dbus_wdata_o;
      end
      if (done_o) begin done_cnt++; last_done = cyc; end
      if (error_o) last_err = cyc;
    end
  end

  initial begin
    int v0, d0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    dbus_if.dbus_ready_i = 1'b0;
    dbus_if.dbus_rdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(dbus_if.dbus_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_addr", dbus_if.dbus_addr_o, 32'd0);
    chk("rst_wdata", dbus_if.dbus_wdata_o, 32'd0);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // Reset leaves registers zero.
    run(mk(0, 7, 2, 0), 32'h0, 32'h10, 0, 0);
    chk("rst_reg_zero", obs_wdata, 32'h0);

    // REG->REG latency and no bus traffic.
    run(mk(1, 0, 0, 1), 32'h5, 32'h0, 0, 0);
    v0 = vcnt;
    run(mk(0, 1, 0, 2), 32'h0, 32'h0, 0, 0);
    chk("rr_latency", 32'(last_done - g_acc), 32'd3);
    chk("rr_no_valid", 32'(vcnt - v0), 32'd0);
    run(mk(0, 2, 2, 0), 32'h0, 32'h200, 0, 0);
    chk("rr_r2", obs_wdata, 32'h5);
    chk("rr_r2_addr", obs_addr, 32'h200);

    // IMM->MEM_ABS with ready three cycles late.
    v0 = vcnt;
    run(mk(1, 0, 2, 0), 32'hDEADBEEF, 32'h100, 0, 3);
    chk("imm_valid_len", 32'(vcnt - v0), 32'd4);
    chk("imm_addr", obs_addr, 32'h100);
    chk("imm_we", 32'(obs_we), 32'd1);
    chk("imm_wdata", obs_wdata, 32'hDEADBEEF);

    // MEM_IND->REG through r3.
    run(mk(1, 0, 0, 3), 32'h40, 32'h0, 0, 0);
    mem[32'h40] = 32'h1234;
    run(mk(3, 3, 0, 4), 32'h0, 32'h0, 2, 0);
    chk("ind_addr", obs_addr, 32'h40);
    chk("ind_we", 32'(obs_we), 32'd0);
    op_i = mk(3, 3, 0, 4);
    #1;
    chk("ind_need_src", 32'(need_src_operand_o), 32'd0);
    run(mk(0, 4, 2, 0), 32'h0, 32'h204, 0, 1);
    chk("ind_r4", obs_wdata, 32'h1234);

    // Illegal dst kind 1.
    v0 = vcnt;
    run(mk(1, 0, 1, 5), 32'h77, 32'h0, 0, 0);
    chk("ill_latency", 32'(last_err - g_acc), 32'd1);
    chk("ill_done_with_err", 32'(last_done), 32'(last_err));
    chk("ill_no_valid", 32'(vcnt - v0), 32'd0);
    run(mk(0, 5, 2, 0), 32'h0, 32'h208, 0, 0);
    chk("ill_r5", obs_wdata, 32'h0);

    // Starts while busy are ignored.
    d0 = done_cnt;
    g_ws = 0; g_wd = 0;
    step(1'b1, mk(1, 0, 0, 6), 32'h7, 32'h0);
    step(1'b1, mk(1, 0, 0, 6), 32'h9, 32'h0);
    step(1'b1, mk(1, 0, 0, 6), 32'h9, 32'h0);
    wait_idle();
    chk("busy_one_done", 32'(done_cnt - d0), 32'd1);
    run(mk(0, 6, 2, 0), 32'h0, 32'h20C, 0, 0);
    chk("busy_r6", obs_wdata, 32'h7);

    // Asynchronous reset while in DST_WAIT.
    g_ws = 0; g_wd = 20;
    step(1'b1, mk(1, 0, 2, 0), 32'h55, 32'h300);
    repeat (4) step(1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("pre_arst_valid", 32'(dbus_if.dbus_valid_o), 32'd1);
    chk_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(dbus_if.dbus_valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_addr", dbus_if.dbus_addr_o, 32'd0);
    tl.delete();
    for (int i = 0; i < 16; i++) regs[i] = '0;
    if (pend_v) begin
      if (pend_existed) mem[pend_a] = pend_old;
      else mem.delete(pend_a);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    chk_en = 1'b1;
    run(mk(1, 0, 0, 9), 32'hCAFE, 32'h0, 0, 0);
    run(mk(0, 9, 3, 9), 32'h0, 32'h0, 0, 2);
    chk("post_rst_addr", obs_addr, 32'hCAFE);
    chk("post_rst_wdata", obs_wdata, 32'hCAFE);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      g_ws = $urandom_range(0, 3);
      g_wd = $urandom_range(0, 3);
      step(1'($urandom_range(0, 2) == 0),
           {4'($urandom_range(0, 4)), 4'($urandom), 4'($urandom_range(0, 4)), 4'($urandom), 16'($urandom)},
           $urandom, $urandom);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/transport_unit.md
TRANSPORT_UNIT -- requirements
Module: transport_unit

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have ports op_i, src_operand_i, dst_operand_i, each input, 32: instruction word and operands from the upstream sequencer.
REQ-004 SHALL have port start_i, input, 1: one-cycle pulse meaning op_i and operands are valid this cycle.
REQ-005 SHALL have ports need_src_operand_o and need_dst_operand_o, each output, 1: combinational decode of op_i for the sequencer.
REQ-006 SHALL have port busy_o, output, 1: high whenever the state is not IDLE.
REQ-007 SHALL have ports done_o and error_o, each output, 1: completion pulse and fault pulse.
REQ-008 SHALL have data-bus master ports dbus_valid_o (1), dbus_we_o (1), dbus_addr_o (32), dbus_wdata_o (32), all outputs, plus inputs dbus_ready_i (1) and dbus_rdata_i (32).

Function
REQ-009 SHALL decode op fields: [31:28] src kind, [27:24] src reg, [23:20] dst kind, [19:16] dst reg; bits [15:0] are ignored.
REQ-010 SHALL support src kinds REG=0 (reg value), IMM=1 (src operand), MEM_ABS=2 (mem[src operand]), MEM_IND=3 (mem[reg]).
REQ-011 SHALL support dst kinds REG=0, MEM_ABS=2 (address = dst operand), MEM_IND=3 (address = reg); dst IMM and every kind value >3 are illegal.
REQ-012 SHALL drive need_src_operand_o high iff src kind is IMM or MEM_ABS, and need_dst_operand_o high iff dst kind is MEM_ABS.
REQ-013 SHALL implement states IDLE, SRC, SRC_WAIT, DST, DST_WAIT, DONE, ERR.
REQ-014 IDLE: on start_i, SHALL latch op and both operands; a legal op goes to SRC, an illegal op goes to ERR.
REQ-015 SRC: REG/IMM SHALL load the data register and go to DST; MEM kinds SHALL register the address, clear we, and go to SRC_WAIT.
REQ-016 SRC_WAIT: SHALL hold the bus request; on dbus_ready_i it SHALL capture dbus_rdata_i and go to DST.
REQ-017 DST: REG SHALL write the register file and go to DONE; MEM kinds SHALL register the address and wdata, set we, and go to DST_WAIT.
REQ-018 DST_WAIT: on dbus_ready_i SHALL go to DONE.
REQ-019 SHALL drive dbus_valid_o = (state==SRC_WAIT || state==DST_WAIT); valid stays high from the first wait cycle through the ready cycle inclusive, then drops.
REQ-020 SHALL keep addr, we and wdata stable while dbus_valid_o is high.
REQ-021 DONE SHALL pulse done_o for one cycle and return to IDLE; ERR SHALL pulse done_o and error_o together for one cycle and return to IDLE, with no register or bus write.
REQ-022 SHALL ignore start_i while busy_o is high.
REQ-023 SHALL give a REG->REG move with start_i at cycle N a done_o at N+3; each memory access adds 1 + wait cycles.
REQ-024 MEM_IND addresses SHALL use the register value read in SRC/DST of the current move; reg-to-self moves are legal.
REQ-025 SHALL not wrap or check addresses (full 32-bit pass-through).

Reset
REQ-026 On rst_ni low, SHALL immediately set state IDLE; dbus_valid_o, dbus_we_o, done_o, error_o, busy_o = 0; dbus_addr_o and dbus_wdata_o = 0; all 16 registers = 0.
REQ-027 Reset during SRC_WAIT or DST_WAIT SHALL drop dbus_valid_o asynchronously and discard the move.

Structure
REQ-028 Package tta_pkg SHALL hold the kind enum, the op field bit positions, and the state enum.
REQ-029 SHALL instantiate one sub-module reg_file: 16x32, two async read ports (src reg, dst reg), one sync write port, async active-low reset.

Verification
REQ-030 REG->REG: r1=0x5 (preloaded), move r1->r2, start at N -> done_o at N+3, r2=0x5, dbus_valid_o never high.
REQ-031 IMM->MEM_ABS: src=0xDEADBEEF, dst operand=0x100, ready delayed 3 cycles -> valid high 4 cycles, we=1, addr=0x100, wdata=0xDEADBEEF held stable, then done_o.
REQ-032 MEM_IND->REG: r3=0x40, mem[0x40]=0x1234 -> read at addr 0x40 with we=0, r4=0x1234; need_src_operand_o=0 for this op.
REQ-033 Illegal dst kind 1 -> done_o and error_o high the same single cycle, registers unchanged, no bus request.
REQ-034 Assert rst_ni mid-DST_WAIT -> dbus_valid_o low without waiting for a clock edge, state IDLE, next legal move completes normally.
REQ-035 start_i pulsed while busy -> ignored; exactly one done_o per accepted move.
